// File: rtl/ag_tcu_pe_router_pkg.sv
// Shared types for the tensor-unit PE router: engine ids, format-to-engine mapping, select width.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ag_tcu_pe_router_pkg;

    typedef enum logic [2:0] {
        PE_FP  = 3'd0,
        PE_INT = 3'd1,
        PE_MIX = 3'd2
    } ag_tcu_pe_e;

    localparam int AG_TCU_PE_COUNT = 3;

    typedef enum logic [1:0] {
        FMT_FP16 = 2'd0,
        FMT_FP32 = 2'd1,
        FMT_INT8 = 2'd2,
        FMT_MIX  = 2'd3
    } ag_tcu_fmt_e;

    // Dispatch uses this to drive in_sel from the instruction's operand format.
    function automatic ag_tcu_pe_e fmt_to_pe(input ag_tcu_fmt_e fmt_s);
        case (fmt_s)
            FMT_FP16, FMT_FP32: return PE_FP;
            FMT_INT8:           return PE_INT;
            default:            return PE_MIX;
        endcase
    endfunction

    // Select width never drops below one bit, even for a single engine.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ag_tcu_order_fifo.sv
// Order-tag FIFO: remembers which PE each accepted request went to, oldest first.
// Latency: push visible at head the cycle after; head is a combinational read of the oldest entry.
// Backpressure: caller must not push when full nor pop when empty; simultaneous push/pop allowed.
// Ports: clk, reset (sync, active-high), push/push_dat, pop, head, full, empty.
module ag_tcu_order_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit: equal low bits with differing MSB means full.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ag_tcu_pe_router.sv
// Fans one execute stream out to PE_COUNT engines and returns their responses strictly in issue order.
// Latency: request path combinational; response path 1 cycle (OUT_REG=1) or 0 cycles (OUT_REG=0).
// Backpressure: in_ready drops on full order FIFO, exhausted PE credit or PE not ready; only the head PE is popped.
// Ports: in_* request stream, pe_req_* shared request bus with one-hot valid, pe_rsp_* per-PE responses,
//        out_* ordered response stream with producing PE, busy, sticky err_sel for out-of-range selects.
module ag_tcu_pe_router
    import ag_tcu_pe_router_pkg::*;
#(
    parameter int PE_COUNT    = 2,
    parameter int REQ_W       = 64,
    parameter int RSP_W       = 64,
    parameter int ORDER_DEPTH = 8,
    parameter int MAX_OUT     = 4,
    parameter int OUT_REG     = 1,
    localparam int SEL_W      = sel_width(PE_COUNT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [REQ_W-1:0]          in_data,
    output logic                      in_ready,
    output logic [PE_COUNT-1:0]       pe_req_valid,
    output logic [REQ_W-1:0]          pe_req_data,
    input  logic [PE_COUNT-1:0]       pe_req_ready,
    input  logic [PE_COUNT-1:0]       pe_rsp_valid,
    input  logic [PE_COUNT*RSP_W-1:0] pe_rsp_data,
    output logic [PE_COUNT-1:0]       pe_rsp_ready,
    output logic                      out_valid,
    output logic [RSP_W-1:0]          out_data,
    output logic [SEL_W-1:0]          out_pe,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err_sel
);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [CW-1:0]       credit [PE_COUNT];
    logic                fifo_full;
    logic                fifo_empty;
    logic [SEL_W-1:0]    head;
    logic [PE_COUNT-1:0] sel_hit;
    logic [PE_COUNT-1:0] cred_ok;
    logic [PE_COUNT-1:0] head_hit;
    logic [PE_COUNT-1:0] has_credit;
    logic [RSP_W-1:0]    head_dat;
    logic                sel_legal;
    logic                accept;
    logic                retire;
    logic                stage_free;
    logic                reg_full;

    // Decode by loop rather than comparing in_sel against PE_COUNT, so
    // out-of-range selects simply match nothing.
    always_comb begin
        sel_hit    = '0;
        cred_ok    = '0;
        head_hit   = '0;
        has_credit = '0;
        head_dat   = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            sel_hit[i]    = (in_sel == SEL_W'(i));
            cred_ok[i]    = (credit[i] < CW'(MAX_OUT));
            has_credit[i] = (credit[i] != '0);
            head_hit[i]   = !fifo_empty && (head == SEL_W'(i));
            if (head_hit[i]) head_dat = pe_rsp_data[i*RSP_W +: RSP_W];
        end
    end

    assign sel_legal = |sel_hit;

    // Illegal selects are swallowed (ready=1) so the stream never deadlocks on them.
    assign in_ready     = !sel_legal || (!fifo_full && |(sel_hit & cred_ok & pe_req_ready));
    // Valid is formed without the target's own ready to avoid a combinational loop through the PE.
    assign pe_req_valid = (in_valid && !fifo_full && !reset) ? (sel_hit & cred_ok) : '0;
    assign pe_req_data  = in_data;
    assign accept       = in_valid && in_ready && sel_legal;

    assign pe_rsp_ready = (stage_free && !reset) ? head_hit : '0;
    assign retire       = |(pe_rsp_valid & pe_rsp_ready);

    ag_tcu_order_fifo #(
        .DEPTH (ORDER_DEPTH),
        .W     (SEL_W)
    ) u_order_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (in_sel),
        .pop      (retire),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Same-PE accept and retire in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PE_COUNT; i++) credit[i] <= '0;
        end else begin
            for (int i = 0; i < PE_COUNT; i++) begin
                case ({accept && sel_hit[i], retire && head_hit[i]})
                    2'b10:   credit[i] <= credit[i] + CW'(1);
                    2'b01:   credit[i] <= credit[i] - CW'(1);
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                        err_sel <= 1'b0;
        else if (in_valid && !sel_legal)  err_sel <= 1'b1;
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic             out_vld_q;
            logic [RSP_W-1:0] out_dat_q;
            logic [SEL_W-1:0] out_pe_q;

            // Loads whenever the slot is empty or draining, giving one response per cycle.
            assign stage_free = !out_vld_q || out_ready;
            assign reg_full   = out_vld_q;

            always_ff @(posedge clk) begin
                if (reset)           out_vld_q <= 1'b0;
                else if (stage_free) out_vld_q <= retire;
            end

            // Payload only moves on a retire, so it holds steady through a stall.
            always_ff @(posedge clk) begin
                if (stage_free && retire) begin
                    out_dat_q <= head_dat;
                    out_pe_q  <= head;
                end
            end

            assign out_valid = out_vld_q && !reset;
            assign out_data  = out_dat_q;
            assign out_pe    = out_pe_q;
        end else begin : g_comb
            logic head_vld;

            assign head_vld   = |(head_hit & pe_rsp_valid);
            assign stage_free = out_ready;
            assign reg_full   = 1'b0;
            assign out_valid  = head_vld && !reset;
            assign out_data   = head_dat;
            assign out_pe     = head;
        end
    endgenerate

    assign busy = !fifo_empty || reg_full;

    // A PE answering with no tag outstanding would be held forever.
    a_rsp_without_tag: assert property (@(posedge clk) disable iff (reset)
        (pe_rsp_valid & ~has_credit) == '0);

endmodule
